block_out_packetizer: RTL and testbench

- Upstream feeder for the host-bound (block-out) path of the EPT endpoint transfer logic.
- Buffers bytes produced by the KIM-1 core in a synchronous FIFO and decides when to send a packet: either the FIFO holds PKT_MAX bytes, the producer has gone idle, or a flush is requested.
- Drives start_transfer, uc_length and transfer_to_host to the block-out stage.
- Advances one byte per transfer_ready strobe until the packet is drained.

---
 rtl/block_out_packetizer_pkg.sv | 15 +
 rtl/sync_byte_fifo.sv | 61 ++++++
 rtl/block_out_packetizer.sv | 136 +++++++++++++
 tb/tb_block_out_packetizer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_out_packetizer_pkg.sv
// Shared widths and FSM encodings for the host-bound block-out packetizer.
package block_out_packetizer_pkg;

  localparam int unsigned UC_DATAIN_W  = 8;
  localparam int unsigned UC_DATAOUT_W = 8;
  localparam int unsigned EPT_LENGTH_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StSend  = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// First-word-fall-through byte FIFO with single-step discard of several head entries.
module sync_byte_fifo
  import block_out_packetizer_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    drop,
  input  logic [CW-1:0]           drop_cnt,
  input  logic [UC_DATAIN_W-1:0]  din,
  output logic [UC_DATAOUT_W-1:0] dout,
  output logic                    full,
  output logic                    empty,
  output logic [CW-1:0]           count
);

  logic [UC_DATAIN_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_push;
  logic                   w_pop;
  logic [CW-1:0]          w_dec;

  always_comb begin
    full   = (r_count == CW'(DEPTH));
    empty  = (r_count == '0);
    w_push = push & ~full;
    w_pop  = pop & ~empty & ~drop;
    w_dec  = drop ? drop_cnt : (w_pop ? CW'(1) : '0);
    dout   = empty ? '0 : r_mem[r_rd_ptr];
    count  = r_count;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      // Low bits of the discard count suffice: pointers wrap modulo DEPTH.
      r_rd_ptr <= r_rd_ptr + w_dec[AW-1:0];
      r_count  <= r_count + CW'(w_push) - w_dec;
    end
  end

endmodule

// File: rtl/block_out_packetizer.sv
// Buffers core bytes and launches block-out packets on full size, producer idle or flush.
module block_out_packetizer
  import block_out_packetizer_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned PKT_MAX      = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned XFER_TIMEOUT = 65535,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                    uc_clk,
  input  logic                    uc_reset,
  input  logic [UC_DATAIN_W-1:0]  wr_data,
  input  logic                    wr_en,
  output logic                    wr_full,
  input  logic                    flush,
  output logic                    start_transfer,
  output logic [EPT_LENGTH_W-1:0] uc_length,
  output logic [UC_DATAOUT_W-1:0] transfer_to_host,
  input  logic                    transfer_ready,
  input  logic                    transfer_busy,
  output logic [CW-1:0]           fifo_count,
  output logic                    overflow,
  output logic                    xfer_error,
  output logic                    pkt_active
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned XW = $clog2(XFER_TIMEOUT + 1);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [EPT_LENGTH_W-1:0] r_len;
  logic [EPT_LENGTH_W-1:0] r_rem;
  logic [IW-1:0]           r_idle_cnt;
  logic [XW-1:0]           r_xto_cnt;
  logic [CW-1:0]           r_flush_cnt;
  logic                    r_overflow;
  logic                    r_xfer_error;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_abort;
  logic                    w_launch;
  logic [CW-1:0]           w_dec;
  logic [EPT_LENGTH_W-1:0] w_len;

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (uc_clk),
    .rst      (uc_reset),
    .push     (wr_en),
    .pop      (w_pop),
    .drop     (w_abort),
    .drop_cnt (w_dec),
    .din      (wr_data),
    .dout     (transfer_to_host),
    .full     (wr_full),
    .empty    (w_empty),
    .count    (fifo_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_len    = (fifo_count >= CW'(PKT_MAX)) ? EPT_LENGTH_W'(PKT_MAX)
                                            : EPT_LENGTH_W'(fifo_count);
    w_pop    = (r_state == StSend) && transfer_ready && (r_rem != '0);
    w_abort  = (r_state == StSend) && !transfer_ready && (r_xto_cnt == XW'(XFER_TIMEOUT));
    w_launch = (r_state == StIdle) && !w_empty &&
               ((fifo_count >= CW'(PKT_MAX)) || (r_idle_cnt == IW'(IDLE_TIMEOUT)) ||
                (r_flush_cnt != '0));
    w_dec    = w_pop ? CW'(1) : (w_abort ? CW'(r_rem) : '0);
    unique case (r_state)
      StIdle:  if (w_launch) w_state_next = StArm;
      StArm:   w_state_next = StSend;
      StSend: begin
        if (w_abort) w_state_next = StIdle;
        else if (w_pop && (r_rem == EPT_LENGTH_W'(1))) w_state_next = StDrain;
      end
      StDrain: if (!transfer_busy) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge uc_clk) begin
    if (uc_reset) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_rem        <= '0;
      r_idle_cnt   <= '0;
      r_xto_cnt    <= '0;
      r_flush_cnt  <= '0;
      r_overflow   <= 1'b0;
      r_xfer_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_launch) begin
        r_len <= w_len;
        r_rem <= w_len;
      end else if (w_abort) begin
        r_rem <= '0;
      end else if (w_pop) begin
        r_rem <= r_rem - EPT_LENGTH_W'(1);
      end
      if (wr_en) begin
        r_idle_cnt <= '0;
      end else if (!w_empty && (r_idle_cnt != IW'(IDLE_TIMEOUT))) begin
        r_idle_cnt <= r_idle_cnt + IW'(1);
      end
      if ((r_state == StSend) && !transfer_ready && !w_abort) begin
        r_xto_cnt <= r_xto_cnt + XW'(1);
      end else begin
        r_xto_cnt <= '0;
      end
      // Flush covers only the bytes buffered when it arrives; later pushes wait for idle.
      if (flush && !w_empty) begin
        r_flush_cnt <= fifo_count - w_dec;
      end else if (r_flush_cnt > w_dec) begin
        r_flush_cnt <= r_flush_cnt - w_dec;
      end else begin
        r_flush_cnt <= '0;
      end
      r_overflow   <= r_overflow | (wr_en & wr_full);
      r_xfer_error <= r_xfer_error | w_abort;
    end
  end

  always_comb begin
    start_transfer = (r_state == StArm);
    pkt_active     = (r_state != StIdle);
    uc_length      = r_len;
    overflow       = r_overflow;
    xfer_error     = r_xfer_error;
  end

endmodule

// File: tb/tb_block_out_packetizer.sv
// Directed bench for block_out_packetizer: a cycle table plus hand-built corner sequences.
module tb_block_out_packetizer;

  localparam int unsigned IDLE_TO = 20;
  localparam int unsigned XFER_TO = 100;

  logic       uc_clk = 1'b0;
  logic       uc_reset = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       wr_full;
  logic       flush = 1'b0;
  logic       start_transfer;
  logic [7:0] uc_length;
  logic [7:0] transfer_to_host;
  logic       transfer_ready = 1'b0;
  logic       transfer_busy = 1'b0;
  logic [5:0] fifo_count;
  logic       overflow;
  logic       xfer_error;
  logic       pkt_active;

  int n_tests = 0;
  int n_fail = 0;

  block_out_packetizer #(
    .DEPTH        (32),
    .PKT_MAX      (16),
    .IDLE_TIMEOUT (IDLE_TO),
    .XFER_TIMEOUT (XFER_TO)
  ) dut (
    .uc_clk           (uc_clk),
    .uc_reset         (uc_reset),
    .wr_data          (wr_data),
    .wr_en            (wr_en),
    .wr_full          (wr_full),
    .flush            (flush),
    .start_transfer   (start_transfer),
    .uc_length        (uc_length),
    .transfer_to_host (transfer_to_host),
    .transfer_ready   (transfer_ready),
    .transfer_busy    (transfer_busy),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .xfer_error       (xfer_error),
    .pkt_active       (pkt_active)
  );

  always #5 uc_clk = ~uc_clk;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       fl;
    logic       rdy;
    logic       bsy;
    logic [5:0] cnt;
    logic       st;
    logic       act;
    logic [7:0] th;
    logic [7:0] len;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge uc_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    transfer_ready = 1'b0;
    transfer_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    uc_reset = 1'b1;
    tick();
    tick();
    uc_reset = 1'b0;
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Ticks until start_transfer is seen; k = ticks taken, or bound+1 if never seen.
  task automatic wait_start(input int bound, output int k);
    k = 0;
    while (k <= bound) begin
      tick();
      k++;
      if (start_transfer) return;
    end
  endtask

  function automatic void add(input logic we, input logic [7:0] wd, input logic fl,
                              input logic rdy, input logic bsy, input logic [5:0] cnt,
                              input logic st, input logic act, input logic [7:0] th,
                              input logic [7:0] len);
    vec_t v;
    v.we = we; v.wd = wd; v.fl = fl; v.rdy = rdy; v.bsy = bsy;
    v.cnt = cnt; v.st = st; v.act = act; v.th = th; v.len = len;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n_start;

    // Flushed 3-byte packet, one cycle per row.
    add(1, 8'hA0, 0, 0, 0, 1, 0, 0, 8'hA0, 0);
    add(1, 8'hA1, 0, 0, 0, 2, 0, 0, 8'hA0, 0);
    add(1, 8'hA2, 0, 0, 0, 3, 0, 0, 8'hA0, 0);
    add(0, 8'h00, 1, 0, 0, 3, 0, 0, 8'hA0, 0);
    add(0, 8'h00, 0, 0, 0, 3, 1, 1, 8'hA0, 3);
    add(0, 8'h00, 0, 0, 0, 3, 0, 1, 8'hA0, 3);
    add(0, 8'h00, 0, 1, 1, 2, 0, 1, 8'hA1, 3);
    add(0, 8'h00, 0, 0, 1, 2, 0, 1, 8'hA1, 3);
    add(0, 8'h00, 0, 1, 1, 1, 0, 1, 8'hA2, 3);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00, 3);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, 8'h00, 3);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 3);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 3);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 3);

    do_reset();
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_full", 32'(wr_full), 0);
    chk("rst_start", 32'(start_transfer), 0);
    chk("rst_len", 32'(uc_length), 0);
    chk("rst_active", 32'(pkt_active), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_xerr", 32'(xfer_error), 0);
    chk("rst_thost", 32'(transfer_to_host), 0);

    foreach (tbl[i]) begin
      wr_en = tbl[i].we;
      wr_data = tbl[i].wd;
      flush = tbl[i].fl;
      transfer_ready = tbl[i].rdy;
      transfer_busy = tbl[i].bsy;
      tick();
      chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_start", i), 32'(start_transfer), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_active", i), 32'(pkt_active), 32'(tbl[i].act));
      chk($sformatf("tbl%0d_thost", i), 32'(transfer_to_host), 32'(tbl[i].th));
      chk($sformatf("tbl%0d_len", i), 32'(uc_length), 32'(tbl[i].len));
    end
    idle_inputs();

    // Full-size packet, ready every third cycle.
    do_reset();
    push_bytes(16, 8'h00);
    wait_start(5, k);
    chk("full_start_delay", 32'(k), 1);
    chk("full_len", 32'(uc_length), 16);
    tick();
    chk("full_pulse_width", 32'(start_transfer), 0);
    transfer_busy = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("full_byte%0d", b), 32'(transfer_to_host), 32'(b));
      transfer_ready = 1'b1;
      tick();
      transfer_ready = 1'b0;
      tick();
      tick();
    end
    chk("full_drain_active", 32'(pkt_active), 1);
    chk("full_drain_count", 32'(fifo_count), 0);
    transfer_busy = 1'b0;
    tick();
    chk("full_idle", 32'(pkt_active), 0);

    // Short packet after producer idle.
    do_reset();
    push_bytes(5, 8'h10);
    wait_start(100, k);
    chk("idle_start_delay", 32'(k), IDLE_TO + 1);
    chk("idle_len", 32'(uc_length), 5);
    tick();
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("idle_byte%0d", b), 32'(transfer_to_host), 32'(8'h10 + b));
      transfer_ready = 1'b1;
      tick();
    end
    transfer_ready = 1'b0;
    tick();
    chk("idle_done", 32'(pkt_active), 0);
    chk("idle_count", 32'(fifo_count), 0);

    // Overflow: 40 pushes into a 32-deep FIFO with nothing draining.
    do_reset();
    n_start = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
      if (start_transfer) n_start++;
    end
    wr_en = 1'b0;
    chk("ovf_count", 32'(fifo_count), 32);
    chk("ovf_full", 32'(wr_full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_len", 32'(uc_length), 16);
    chk("ovf_starts", 32'(n_start), 1);
    chk("ovf_head", 32'(transfer_to_host), 0);

    // Flush, plus a push alongside a pop that forms a later one-byte packet.
    do_reset();
    push_bytes(3, 8'h30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(5, k);
    chk("flush_start_delay", 32'(k), 1);
    chk("flush_len", 32'(uc_length), 3);
    tick();
    transfer_busy = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    transfer_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("flush_pushpop_count", 32'(fifo_count), 3);
    chk("flush_pushpop_head", 32'(transfer_to_host), 32'h31);
    tick();
    tick();
    transfer_ready = 1'b0;
    transfer_busy = 1'b0;
    chk("flush_left", 32'(fifo_count), 1);
    chk("flush_len_hold", 32'(uc_length), 3);
    wait_start(100, k);
    chk("flush_second_delay", 32'(k + 2), IDLE_TO + 1);
    chk("flush_second_len", 32'(uc_length), 1);
    chk("flush_second_byte", 32'(transfer_to_host), 32'h77);

    // Transfer timeout abort.
    do_reset();
    push_bytes(4, 8'h40);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(5, k);
    chk("xto_start", 32'(start_transfer), 1);
    transfer_busy = 1'b1;
    k = 0;
    while (!xfer_error && k < 300) begin
      tick();
      k++;
    end
    chk("xto_delay", 32'(k), XFER_TO + 2);
    chk("xto_err", 32'(xfer_error), 1);
    chk("xto_count", 32'(fifo_count), 0);
    chk("xto_active", 32'(pkt_active), 0);
    tick();
    chk("xto_no_restart", 32'(start_transfer), 0);
    transfer_busy = 1'b0;

    // Reset mid-packet with 8 bytes still to send.
    do_reset();
    push_bytes(12, 8'h60);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start(5, k);
    chk("mid_len", 32'(uc_length), 12);
    tick();
    transfer_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      transfer_ready = 1'b1;
      tick();
    end
    transfer_ready = 1'b0;
    chk("mid_count", 32'(fifo_count), 8);
    chk("mid_head", 32'(transfer_to_host), 32'h64);
    uc_reset = 1'b1;
    tick();
    uc_reset = 1'b0;
    transfer_busy = 1'b0;
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_start", 32'(start_transfer), 0);
    chk("mid_rst_active", 32'(pkt_active), 0);
    chk("mid_rst_len", 32'(uc_length), 0);
    chk("mid_rst_thost", 32'(transfer_to_host), 0);
    chk("mid_rst_full", 32'(wr_full), 0);
    n_start = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (start_transfer) n_start++;
    end
    chk("mid_rst_no_start", 32'(n_start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
